// File: rtl/shift_sequencer.sv
// shift_sequencer: round-robin arbiter that steps one requester's word through a shared single-step shifter.
module shift_sequencer #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [W-1:0]  req0_data,
  input  logic          req0_lr,
  input  logic [AW-1:0] req0_amt,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [W-1:0]  req1_data,
  input  logic          req1_lr,
  input  logic [AW-1:0] req1_amt,
  output logic [W-1:0]  sh_in,
  output logic          sh_lr,
  input  logic [W-1:0]  sh_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_data,
  output logic          res_id,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [AW-1:0] cnt_q, cnt_d, amt;
  logic          dir_q, dir_d, id_q, id_d, last_q, last_d;
  logic          g0, g1, take;
  always_comb begin
    g1      = req1_valid & (~req0_valid | ~last_q);
    g0      = req0_valid & ~g1;
    take    = (state_q == IDLE) & (g0 | g1);
    amt     = g1 ? req1_amt : req0_amt;
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    id_d    = id_q;
    last_d  = last_q;
    if (take) begin
      acc_d   = g1 ? req1_data : req0_data;
      dir_d   = g1 ? req1_lr : req0_lr;
      cnt_d   = amt;
      id_d    = g1;
      last_d  = g1;
      state_d = (amt != '0) ? RUN : DONE;
    end else if (state_q == RUN) begin
      acc_d   = sh_out;
      cnt_d   = cnt_q - 1'b1;
      state_d = (cnt_q == AW'(1)) ? DONE : RUN;
    end else if (state_q == DONE && res_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end
  // readies are gated by rst_n so nothing is offered while reset is held
  assign req0_ready = rst_n & (state_q == IDLE) & g0;
  assign req1_ready = rst_n & (state_q == IDLE) & g1;
  assign sh_in      = acc_q;
  assign sh_lr      = dir_q;
  assign res_valid  = state_q == DONE;
  assign res_data   = acc_q;
  assign res_id     = id_q;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: randomized and directed checks of shift_sequencer against a rotate-shifter reference model.
module tb_shift_sequencer;
  logic       clk = 0, rst_n = 0;
  logic       req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [7:0] req0_data = 0, req1_data = 0;
  logic       req0_lr = 0, req1_lr = 0;
  logic [2:0] req0_amt = 0, req1_amt = 0;
  logic [7:0] sh_in, sh_out, res_data;
  logic       sh_lr, res_valid, res_ready = 0, res_id, busy;
  always #5 clk = ~clk;
  assign sh_out = sh_lr ? {sh_in[6:0], sh_in[7]} : {sh_in[0], sh_in[7:1]};
  shift_sequencer #(.W(8), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_lr(req0_lr), .req0_amt(req0_amt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_lr(req1_lr), .req1_amt(req1_amt),
    .sh_in(sh_in), .sh_lr(sh_lr), .sh_out(sh_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id), .busy(busy)
  );
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask
  function automatic logic [7:0] rot(input logic [7:0] d, input int k, input logic l);
    logic [15:0] dd;
    dd = {d, d};
    return l ? dd[15-k -: 8] : dd[7+k -: 8];
  endfunction
  function automatic int pick(input logic v0, input logic v1, input logic l);
    return (v0 && v1) ? (l ? 0 : 1) : v0 ? 0 : v1 ? 1 : -1;
  endfunction
  // reference: an op holds the original word and counts passes done; result is a closed-form rotate
  bit         m_busy = 0;
  int         m_j = 0, m_k = 0, m_p;
  logic [7:0] m_data = 0;
  logic       m_dir = 0, m_id = 0, m_last = 1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_j = 0; m_k = 0; m_data = 0; m_dir = 0; m_id = 0; m_last = 1;
    end else if (!m_busy) begin
      m_p = pick(req0_valid, req1_valid, m_last);
      if (m_p >= 0) begin
        m_busy = 1;
        m_j    = 0;
        m_k    = m_p ? int'(req1_amt) : int'(req0_amt);
        m_data = m_p ? req1_data : req0_data;
        m_dir  = m_p ? req1_lr : req0_lr;
        m_id   = m_p[0];
        m_last = m_p[0];
      end
    end else if (m_j < m_k) m_j++;
    else if (res_ready) m_busy = 0;
  end
  bit   cmp_en = 0;
  int   c_p;
  logic c_ev;
  always @(negedge clk) if (cmp_en) begin
    c_p  = pick(req0_valid, req1_valid, m_last);
    c_ev = m_busy && m_j == m_k;
    chk("res_valid", res_valid, c_ev);
    chk("busy", busy, m_busy);
    chk("req0_ready", req0_ready, rst_n && !m_busy && c_p == 0);
    chk("req1_ready", req1_ready, rst_n && !m_busy && c_p == 1);
    chk("sh_in", sh_in, rot(m_data, m_j, m_dir));
    chk("sh_lr", sh_lr, m_dir);
    if (c_ev || !rst_n) begin
      chk("res_data", res_data, rot(m_data, m_j, m_dir));
      chk("res_id", res_id, m_id);
    end
  end
  logic [7:0] shs [32];
  logic [7:0] rd;
  logic       rid;
  int         lat;
  task automatic drive(input int n, input logic [7:0] d, input logic l, input logic [2:0] a);
    if (n == 0) begin req0_valid = 1; req0_data = d; req0_lr = l; req0_amt = a; end
    else begin req1_valid = 1; req1_data = d; req1_lr = l; req1_amt = a; end
  endtask
  task automatic run_op(input int n, input logic [7:0] d, input logic l, input logic [2:0] a);
    logic got = 0;
    res_ready = 0;
    drive(n, d, l, a);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = n ? req1_ready : req0_ready;
      @(posedge clk); #1;
    end
    if (!got) timeout("accept");
    if (n == 0) req0_valid = 0; else req1_valid = 0;
    lat = 0;
    while (!res_valid && lat < 20) begin
      shs[lat] = sh_in;
      @(posedge clk); #1;
      lat++;
    end
    if (!res_valid) timeout("result");
    rd  = res_data;
    rid = res_id;
  endtask
  task automatic release_res();
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
  endtask
  int exp_g, ngr;
  initial begin
    req0_valid = 1; req1_valid = 1;
    #12;
    chk("rst_res_valid", res_valid, 0); chk("rst_res_data", res_data, 0); chk("rst_res_id", res_id, 0);
    chk("rst_busy", busy, 0); chk("rst_sh_in", sh_in, 0); chk("rst_sh_lr", sh_lr, 0);
    chk("rst_ready0", req0_ready, 0); chk("rst_ready1", req1_ready, 0);
    req0_valid = 0; req1_valid = 0;
    cmp_en = 1;
    @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
    run_op(0, 8'b10101010, 1, 1);
    chk("single_data", rd, 8'b01010101); chk("single_id", rid, 0); chk("single_lat", lat, 1);
    release_res();
    run_op(1, 8'b11101010, 0, 3);
    chk("multi_data", rd, 8'b01011101); chk("multi_id", rid, 1); chk("multi_lat", lat, 3);
    chk("multi_sh0", shs[0], 8'b11101010); chk("multi_sh1", shs[1], 8'b01110101); chk("multi_sh2", shs[2], 8'b10111010);
    release_res();
    run_op(0, 8'b00000010, 1, 0);
    chk("zero_data", rd, 8'b00000010); chk("zero_lat", lat, 0); chk("zero_sh_in", sh_in, 8'b00000010);
    release_res();
    // last grant was requester 0, so alternation must start with requester 1
    res_ready = 1;
    drive(0, 8'h3C, 1, 1); drive(1, 8'hC3, 0, 1);
    exp_g = 1; ngr = 0;
    for (int i = 0; i < 60 && ngr < 6; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        chk("fair_grant", req1_ready, exp_g);
        exp_g ^= 1; ngr++;
      end
      @(posedge clk); #1;
    end
    if (ngr < 6) timeout("fairness");
    req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 10 && busy; i++) begin @(posedge clk); #1; end
    run_op(1, 8'h81, 0, 2);
    chk("bp_data", rd, 8'h60); chk("bp_id", rid, 1);
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", res_valid, 1); chk("bp_hold_data", res_data, 8'h60); chk("bp_hold_id", res_id, 1);
      chk("bp_ready0", req0_ready, 0); chk("bp_ready1", req1_ready, 0); chk("bp_busy", busy, 1);
      @(posedge clk); #1;
    end
    req0_valid = 0; req1_valid = 0;
    res_ready = 1;
    @(posedge clk); #1;
    chk("bp_idle_busy", busy, 0); chk("bp_idle_valid", res_valid, 0);
    res_ready = 0;
    drive(0, 8'hF0, 1, 7);
    for (int i = 0; i < 5 && !req0_ready; i++) @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 0;
    repeat (3) @(posedge clk);
    #1 req0_valid = 1; req1_valid = 1;
    rst_n = 0;
    #1;
    chk("mid_res_valid", res_valid, 0); chk("mid_res_data", res_data, 0); chk("mid_res_id", res_id, 0);
    chk("mid_busy", busy, 0); chk("mid_sh_in", sh_in, 0); chk("mid_sh_lr", sh_lr, 0);
    chk("mid_ready0", req0_ready, 0); chk("mid_ready1", req1_ready, 0);
    req0_valid = 0; req1_valid = 0;
    @(posedge clk); #2 rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_no_result", res_valid, 0);
    end
    @(posedge clk); #1;
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    chk("post_rst_grant0", req0_ready, 1); chk("post_rst_grant1", req1_ready, 0);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      req0_valid = $urandom_range(0, 1); req0_data = 8'($urandom); req0_lr = $urandom_range(0, 1); req0_amt = 3'($urandom);
      req1_valid = $urandom_range(0, 1); req1_data = 8'($urandom); req1_lr = $urandom_range(0, 1); req1_amt = 3'($urandom);
      res_ready = $urandom_range(0, 9) < 7;
      if ($urandom_range(0, 99) == 0) begin
        #1 rst_n = 0;
        #1 rst_n = 1;
      end
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0; res_ready = 0;
    @(negedge clk);
    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
